// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding, bus constants and helpers for uart_tx_arbiter
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WAIT_TX,
        WRITE,
        RELEASE
    } arb_state_t;

    localparam logic [7:0] UART_RXTX_ADDR = 8'h00;

    // Next requester index after idx, wrapping at n.
    function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick from rr pointer, locked to the owner while a packet is open
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    input  logic               lock,
    input  logic [1:0]         owner,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = 2'd0;
        grant_valid = 1'b0;
        if (lock) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner == 2'(i) && req[i]) begin
                    grant[i]    = 1'b1;
                    grant_idx   = 2'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            // Scan from the farthest offset down so the nearest requester at/after ptr wins last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = int'(ptr) + k;
                if (j >= NUM_REQ) begin
                    j = j - NUM_REQ;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == j && req[i]) begin
                        grant       = '0;
                        grant[i]    = 1'b1;
                        grant_idx   = 2'(i);
                        grant_valid = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - byte requesters onto the UART RXTX bus register; UART_ARB_TIMEOUT_EN adds a bus_ack timeout
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [15:0]          bus_data_write,
    output logic [7:0]           bus_addr,
    output logic                 bus_uds,
    output logic                 bus_lds,
    output logic                 bus_rw,
    input  logic                 bus_ack,
    input  logic                 uart_tx_active,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..4 and TIMEOUT >= 1");
    end

    arb_state_t         state;
    logic [1:0]         rr_ptr;
    logic               pkt_open;
    logic [7:0]         byte_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic [1:0]         arb_idx;
    logic               arb_valid;
    logic [7:0]         sel_data;
    logic               sel_last;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .lock       (pkt_open),
        .owner      (grant_id),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_valid(arb_valid)
    );

    always_comb begin
        sel_data = 8'h00;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_data = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    // Accept pulse lands in the same cycle the byte is latched.
    assign req_ready = (state == ARB) ? arb_grant : '0;
    assign busy      = (state != IDLE);
    assign bus_addr  = UART_RXTX_ADDR;
    assign bus_lds   = 1'b0;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int             TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_err_q;

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= 2'd0;
            pkt_open       <= 1'b0;
            grant_id       <= 2'd0;
            byte_q         <= 8'h00;
            bus_uds        <= 1'b0;
            bus_rw         <= 1'b1;
            bus_data_write <= 16'h0000;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
            tmo_err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        grant_id <= arb_idx;
                        byte_q   <= sel_data;
                        if (sel_last) begin
                            pkt_open <= 1'b0;
                            rr_ptr   <= wrap_inc(arb_idx, NUM_REQ);
                        end else begin
                            pkt_open <= 1'b1;
                        end
                        state <= WAIT_TX;
                    end else if (!pkt_open) begin
                        // Requests withdrew before being granted; nothing to hold for.
                        state <= IDLE;
                    end
                end
                WAIT_TX: begin
                    if (!uart_tx_active) begin
                        state          <= WRITE;
                        bus_uds        <= 1'b1;
                        bus_rw         <= 1'b0;
                        bus_data_write <= {byte_q, 8'h00};
`ifdef UART_ARB_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end
                end
                WRITE: begin
                    if (bus_ack) begin
                        state          <= RELEASE;
                        bus_uds        <= 1'b0;
                        bus_rw         <= 1'b1;
                        bus_data_write <= 16'h0000;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Drop the byte and abandon the packet so other requesters get served.
                        state          <= RELEASE;
                        bus_uds        <= 1'b0;
                        bus_rw         <= 1'b1;
                        bus_data_write <= 16'h0000;
                        pkt_open       <= 1'b0;
                        rr_ptr         <= wrap_inc(grant_id, NUM_REQ);
                        tmo_err_q      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    if (pkt_open || (|req_valid)) begin
                        state <= ARB;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 2, number of byte requesters (2..4).
REQ-002 Parameter: TIMEOUT, 4096, max cycles to wait for bus_ack (used only with UART_ARB_TIMEOUT_EN).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester byte valid.
REQ-007 req_data  in  NUM_REQ*8  per-requester byte; requester i at bits [8i+7:8i].
REQ-008 req_last  in  NUM_REQ  byte ends the requester's packet; grant is released after it.
REQ-009 req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-010 bus_data_write  out  16  byte in [15:8], [7:0]=0.
REQ-011 bus_addr  out  8  always 8'h00 (RXTX/STATUS word).
REQ-012 bus_uds, bus_lds, bus_rw  out  1 each  UART bus strobes; lds always 0.
REQ-013 bus_ack  in  1  UART bus acknowledge.
REQ-014 uart_tx_active  in  1  UART transmitter busy.
REQ-015 grant_id  out  2  index of current owner; valid while busy=1.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 timeout_err  out  1  sticky drop flag (only with UART_ARB_TIMEOUT_EN; else tied 0).

Function
REQ-018 FSM states SHALL be IDLE, ARB, WAIT_TX, WRITE, RELEASE.
REQ-019 IDLE: any req_valid -> ARB next cycle; otherwise stay.
REQ-020 ARB: round-robin pick starting at rr_ptr; latch grant_id and byte; req_ready[grant]=1 this cycle; go to WAIT_TX.
REQ-021 rr_ptr SHALL advance to (grant_id+1) mod NUM_REQ only when a byte flagged req_last is accepted.
REQ-022 While a packet is open (last not yet accepted), ARB SHALL consider only the owner; if owner's req_valid=0, FSM waits in ARB.
REQ-023 WAIT_TX: wait until uart_tx_active=0, then go to WRITE.
REQ-024 WRITE: bus_uds=1, bus_rw=0, bus_data_write={byte,8'h00}; held until bus_ack=1.
REQ-025 Cycle after bus_ack seen: bus_uds=0, state RELEASE; a strobe SHALL never span two accepted writes.
REQ-026 RELEASE: one cycle strobes low; -> ARB if packet open or any req_valid, else IDLE.
REQ-027 Outside WRITE: bus_uds=0, bus_rw=1, bus_data_write=0.
REQ-028 Minimum byte-to-byte spacing: ARB->WAIT_TX->WRITE->RELEASE = 4 cycles plus UART wait.
REQ-029 Simultaneous valids with no open packet: lowest index at/after rr_ptr wins.
REQ-030 req_valid dropping after acceptance SHALL not affect the in-flight byte.

Reset
REQ-031 reset=1 SHALL force IDLE, rr_ptr=0, packet closed, grant_id=0, busy=0, req_ready=0, bus_uds=0, bus_rw=1, bus_data_write=0, timeout_err=0.
REQ-032 Reset mid-WRITE SHALL drop the byte; bus_uds low the next cycle.

Configuration
REQ-033 Macro UART_ARB_TIMEOUT_EN defined: counter SHALL reset on entering WRITE; after TIMEOUT cycles without bus_ack, drop byte, close packet, set timeout_err (cleared only by reset), go RELEASE.
REQ-034 Macro undefined: no counter, WRITE waits indefinitely, timeout_err tied 0.

Structure
REQ-035 Package uart_arb_pkg SHALL hold the state enum and constant UART_RXTX_ADDR=8'h00.
REQ-036 Sub-module rr_arbiter (request vector, pointer, lock -> one-hot grant, index) SHALL implement REQ-020/021/022/029.

Verification
REQ-037 req_valid=2'b01, data0=8'h41, last=1, uart_tx_active=0, ack 1 cycle after uds -> one write 16'h4100, req_ready[0] one pulse, busy back to 0.
REQ-038 Both valid, last=1 each, data 8'h11/8'h22 -> writes alternate 8'h11, 8'h22, 8'h11.
REQ-039 Req1 3-byte packet (last on 3rd) with req0 valid -> req1's 3 bytes back-to-back, then req0.
REQ-040 uart_tx_active high 500 cycles -> uds stays 0 in WAIT_TX; write issued first cycle after it drops.
REQ-041 UART_ARB_TIMEOUT_EN, TIMEOUT=16, bus_ack never -> uds drops after 16 cycles, timeout_err=1, next requester served.
REQ-042 reset asserted during WRITE -> bus_uds=0, busy=0 next cycle; no req_ready pulse afterwards.
